muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 34 +++
 rtl/muldiv_sequencer_if.sv | 35 +++
 rtl/muldiv_step.sv | 52 +++++
 rtl/muldiv_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared definitions for the iterative multiply/divide sequencer:
//   - state_e       : FSM state encoding (IDLE / CALC / DONE)
//   - MULT_OP/DIV_OP: op_div encodings
//   - DIV0_QUOT     : quotient reported on divide by zero (all ones),
//                     sliced down to the datapath width by the user
//   - op_ctl_t      : per-operation control captured with start
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MULT_OP = 1'b0;
    localparam logic DIV_OP  = 1'b1;

    // Widest datapath supported; DIV0_QUOT is sliced to DATA_WIDTH.
    localparam int              MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

    // Control captured alongside the operands when a start is accepted.
    //   neg_q : negate product (multiply) or quotient (divide) on completion
    //   neg_r : negate remainder on completion (divide only)
    typedef struct packed {
        logic op_div;
        logic neg_q;
        logic neg_r;
    } op_ctl_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
// Request/response bundle between the decode stage (master) and the
// multiply/divide sequencer (slave).
//   en, start, op_div, op_signed, flush, data_a_in, data_b_in : master -> slave
//   busy, done, div_zero_err, lo_data_out, hi_data_out          : slave -> master
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  en;
    logic                  start;
    logic                  op_div;
    logic                  op_signed;
    logic                  flush;
    logic [DATA_WIDTH-1:0] data_a_in;
    logic [DATA_WIDTH-1:0] data_b_in;
    logic                  busy;
    logic                  done;
    logic                  div_zero_err;
    logic [DATA_WIDTH-1:0] lo_data_out;
    logic [DATA_WIDTH-1:0] hi_data_out;

    modport master (
        output en, start, op_div, op_signed, flush, data_a_in, data_b_in,
        input  busy, done, div_zero_err, lo_data_out, hi_data_out
    );

    modport slave (
        input  en, start, op_div, op_signed, flush, data_a_in, data_b_in,
        output busy, done, div_zero_err, lo_data_out, hi_data_out
    );

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One iteration of the shared multiply/divide datapath (purely combinational).
//   op_div  in  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc     in  : partial product high half / partial remainder
//   mq      in  : multiplier (shifting out LSB-first) / dividend-quotient
//   opb     in  : multiplicand / divisor magnitude
//   acc_nxt out : next acc
//   mq_nxt  out : next mq
// After DATA_WIDTH steps: multiply {acc,mq} = product; divide acc = remainder,
// mq = quotient.
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  op_div,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] mq,
    input  logic [DATA_WIDTH-1:0] opb,
    output logic [DATA_WIDTH-1:0] acc_nxt,
    output logic [DATA_WIDTH-1:0] mq_nxt
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        shifted = {acc, mq[DATA_WIDTH-1]};
        // Partial remainder is always below the divisor, so a non-negative
        // difference fits in DATA_WIDTH bits and the top bit acts as borrow.
        diff    = shifted - {1'b0, opb};

        if (op_div == DIV_OP) begin
            if (!diff[DATA_WIDTH]) begin
                acc_nxt = diff[DATA_WIDTH-1:0];
                mq_nxt  = {mq[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[DATA_WIDTH-1:0];
                mq_nxt  = {mq[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add becomes the new top bit of the pair.
            acc_nxt = sum[DATA_WIDTH:1];
            mq_nxt  = {sum[0], mq[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative multiply / restoring divide, one bit per enabled CALC cycle.
//   clk   in : clock, rising edge
//   rst_n in : synchronous active-low reset (highest priority)
//   bus      : muldiv_sequencer_if.slave (start/operands in, results out)
// Optional feature: define MULDIV_SIGNED_EN to honour op_signed (operands are
// converted to magnitudes on accept, signs corrected on entry to DONE).
// Without it every operation is unsigned.
//
// Timing: start accepted at edge 0 loads the counter with DATA_WIDTH. Edges
// 1..DATA_WIDTH run the steps; at edge DATA_WIDTH+1 the counter is zero and
// the (sign-corrected) result is written as the FSM enters DONE. Divide by
// zero bypasses CALC and enters DONE at edge 0.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    muldiv_sequencer_if.slave bus
);

    // Needs one bit above $clog2 to hold DATA_WIDTH itself.
    localparam int              CW       = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic [DATA_WIDTH-1:0]   acc_q, mq_q, opb_q;
    op_ctl_t                 ctl_q, ctl_d;
    logic [DATA_WIDTH-1:0]   lo_q, hi_q;
    logic                    dz_q;

    logic                    load, step, finish, dz_load;
    logic                    b_zero;
    logic [DATA_WIDTH-1:0]   a_mag, b_mag;
    logic                    neg_q_d, neg_r_d;
    logic [DATA_WIDTH-1:0]   acc_nxt, mq_nxt;
    logic [2*DATA_WIDTH-1:0] prod, prod_fix;
    logic [DATA_WIDTH-1:0]   res_lo, res_hi;

    // ---------------- operand conditioning ----------------
`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    always_comb begin
        a_neg   = bus.op_signed & bus.data_a_in[DATA_WIDTH-1];
        b_neg   = bus.op_signed & bus.data_b_in[DATA_WIDTH-1];
        a_mag   = a_neg ? -bus.data_a_in : bus.data_a_in;
        b_mag   = b_neg ? -bus.data_b_in : bus.data_b_in;
        // Quotient/product negative on sign mismatch; remainder follows dividend.
        neg_q_d = a_neg ^ b_neg;
        neg_r_d = a_neg;
    end
`else
    logic unused_op_signed;
    assign unused_op_signed = bus.op_signed;
    assign a_mag   = bus.data_a_in;
    assign b_mag   = bus.data_b_in;
    assign neg_q_d = 1'b0;
    assign neg_r_d = 1'b0;
`endif

    assign b_zero = (bus.data_b_in == '0);

    always_comb begin
        ctl_d        = ctl_q;
        ctl_d.op_div = bus.op_div;
        ctl_d.neg_q  = neg_q_d;
        ctl_d.neg_r  = neg_r_d;
    end

    // ---------------- FSM next state / controls ----------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        dz_load = 1'b0;
        if (bus.flush) begin
            // Abort wins over en and start; results are left untouched.
            state_d = ST_IDLE;
        end else if (bus.en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.op_div == DIV_OP && b_zero) begin
                            state_d = ST_DONE;
                            dz_load = 1'b1;
                        end else begin
                            state_d = ST_CALC;
                            load    = 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (cnt_q != '0) begin
                        step = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        finish  = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .op_div  (ctl_q.op_div),
        .acc     (acc_q),
        .mq      (mq_q),
        .opb     (opb_q),
        .acc_nxt (acc_nxt),
        .mq_nxt  (mq_nxt)
    );

    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = ctl_q.neg_q ? -prod : prod;
        if (ctl_q.op_div == DIV_OP) begin
            res_lo = ctl_q.neg_q ? -mq_q  : mq_q;
            res_hi = ctl_q.neg_r ? -acc_q : acc_q;
        end else begin
            res_lo = prod_fix[DATA_WIDTH-1:0];
            res_hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opb_q   <= '0;
            ctl_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_q <= CNT_INIT;
                acc_q <= '0;
                mq_q  <= a_mag;
                opb_q <= b_mag;
                ctl_q <= ctl_d;
                dz_q  <= 1'b0;
            end
            if (dz_load) begin
                lo_q <= DIV0_QUOT[DATA_WIDTH-1:0];
                hi_q <= bus.data_a_in;
                dz_q <= 1'b1;
            end
            // Counter stops at zero; it never wraps within an operation.
            if (step) begin
                acc_q <= acc_nxt;
                mq_q  <= mq_nxt;
                cnt_q <= cnt_q - 1'b1;
            end
            if (finish) begin
                lo_q <= res_lo;
                hi_q <= res_hi;
            end
        end
    end

    assign bus.busy         = (state_q == ST_CALC);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.div_zero_err = dz_q;
    assign bus.lo_data_out  = lo_q;
    assign bus.hi_data_out  = hi_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer (DATA_WIDTH = 32). Expected results
// come from plain 64-bit arithmetic; define MULDIV_SIGNED_EN for both bench
// and design to exercise the signed build.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 1;   // done cycle index after the accepting edge

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.DATA_WIDTH(W)) bus ();

    muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {div_zero_err, hi, lo}
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic div, input logic sgn);
        logic [63:0] ua, ub, uq, ur, up;
        longint      sa, sb, sq, sr, sp;
        if (div && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
`ifdef MULDIV_SIGNED_EN
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            if (div) begin
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            sp = sa * sb;
            return {1'b0, sp[63:0]};
        end
`else
        if (sgn) begin
            sa = 0; sb = 0; sq = 0; sr = 0; sp = 0;
        end
`endif
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (div) begin
            uq = ua / ub;
            ur = ua % ub;
            return {1'b0, ur[31:0], uq[31:0]};
        end
        up = ua * ub;
        return {1'b0, up};
    endfunction

    // Issues one op with en high and waits (bounded) for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic div, input logic sgn,
                          output logic [31:0] lo, output logic [31:0] hi,
                          output logic dz, output int lat);
        bus.data_a_in = a;
        bus.data_b_in = b;
        bus.op_div    = div;
        bus.op_signed = sgn;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        lo = bus.lo_data_out;
        hi = bus.hi_data_out;
        dz = bus.div_zero_err;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] lo, hi; logic dz; int lat;
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", bus.done); end
        checks++; if (bus.lo_data_out !== 32'd0 || bus.hi_data_out !== 32'd0 || bus.div_zero_err !== 1'b0) begin
            errors++; $display("FAIL reset_out: got lo=%h hi=%h dz=%b exp 0", bus.lo_data_out, bus.hi_data_out, bus.div_zero_err); end
        rst_n = 1'b1;
        tick();
        run_op(32'd3, 32'd5, 1'b0, 1'b0, lo, hi, dz, lat);
        // reset mid-CALC
        bus.data_a_in = 32'd9; bus.data_b_in = 32'd9; bus.op_div = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b exp 1", bus.busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ctl: got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        checks++; if (bus.lo_data_out !== 32'd0 || bus.hi_data_out !== 32'd0) begin
            errors++; $display("FAIL reset_mid_data: got lo=%h hi=%h exp 0/0", bus.lo_data_out, bus.hi_data_out); end
        run_op(32'd7, 32'd6, 1'b0, 1'b0, lo, hi, dz, lat);
        checks++; if (lo !== 32'd42 || lat != LAT) begin
            errors++; $display("FAIL reset_recover: got lo=%0d lat=%0d exp 42/%0d", lo, lat, LAT); end
    endtask

    task automatic test_mult();
        logic [31:0] lo, hi; logic dz; int lat;
        bus.data_a_in = 32'd7; bus.data_b_in = 32'd6; bus.op_div = 1'b0; bus.op_signed = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b exp 1", bus.busy); end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy_hold: got %b exp 1 at %0d", bus.busy, lat); end
            tick(); lat++;
        end
        checks++; if (lat != LAT) begin errors++; $display("FAIL mult_latency: got %0d exp %0d", lat, LAT); end
        checks++; if (bus.lo_data_out !== 32'd42 || bus.hi_data_out !== 32'd0) begin
            errors++; $display("FAIL mult_7x6: got hi=%h lo=%h exp 0/2a", bus.hi_data_out, bus.lo_data_out); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b exp 0", bus.done); end
        checks++; if (bus.lo_data_out !== 32'd42) begin errors++; $display("FAIL result_hold: got %h exp 2a", bus.lo_data_out); end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lo, hi, dz, lat);
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++; $display("FAIL mult_max: got hi=%h lo=%h exp fffffffe/00000001", hi, lo); end
    endtask

    task automatic test_div();
        logic [31:0] lo, hi; logic dz; int lat;
        run_op(32'd100, 32'd7, 1'b1, 1'b0, lo, hi, dz, lat);
        checks++; if (lo !== 32'd14 || hi !== 32'd2 || lat != LAT) begin
            errors++; $display("FAIL div_100_7: got q=%0d r=%0d lat=%0d exp 14/2/%0d", lo, hi, lat, LAT); end
        run_op(32'd5, 32'd0, 1'b1, 1'b0, lo, hi, dz, lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL div0_latency: got %0d exp 0", lat); end
        checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd5 || dz !== 1'b1) begin
            errors++; $display("FAIL div0_result: got lo=%h hi=%h dz=%b exp ffffffff/5/1", lo, hi, dz); end
        checks++; if (bus.div_zero_err !== 1'b1) begin errors++; $display("FAIL div0_sticky: got %b exp 1", bus.div_zero_err); end
        run_op(32'd9, 32'd3, 1'b1, 1'b0, lo, hi, dz, lat);
        checks++; if (dz !== 1'b0 || lo !== 32'd3 || hi !== 32'd0) begin
            errors++; $display("FAIL div0_clear: got dz=%b q=%0d r=%0d exp 0/3/0", dz, lo, hi); end
    endtask

    task automatic test_signed();
        logic [31:0] lo, hi; logic dz; int lat;
        logic [31:0] exp_lo, exp_hi;
`ifdef MULDIV_SIGNED_EN
        exp_lo = 32'hFFFF_FFFD; exp_hi = 32'hFFFF_FFFF;
`else
        exp_lo = 32'h7FFF_FFFC; exp_hi = 32'h0000_0001;
`endif
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, lo, hi, dz, lat);
        checks++; if (lo !== exp_lo || hi !== exp_hi || lat != LAT) begin
            errors++; $display("FAIL signed_div: got lo=%h hi=%h lat=%0d exp %h/%h/%0d", lo, hi, lat, exp_lo, exp_hi, LAT); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, lo, hi; logic dz, div, sgn; int lat;
        logic [64:0] exp;
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 300));
            div = $urandom_range(0, 1);
            sgn = $urandom_range(0, 1);
            exp = model(a, b, div, sgn);
            run_op(a, b, div, sgn, lo, hi, dz, lat);
            checks++; if ({dz, hi, lo} !== exp || lat != ((div && b == 0) ? 0 : LAT)) begin
                errors++; $display("FAIL random[%0d] a=%h b=%h div=%b sgn=%b: got %b/%h/%h lat=%0d exp %b/%h/%h",
                                   i, a, b, div, sgn, dz, hi, lo, lat, exp[64], exp[63:32], exp[31:0]); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] lo, hi; logic dz; int lat; int done_seen;
        run_op(32'd7, 32'd6, 1'b0, 1'b0, lo, hi, dz, lat);
        bus.data_a_in = 32'd123; bus.data_b_in = 32'd456; bus.op_div = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) done_seen++;
            tick();
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL flush_no_done: got %0d exp 0", done_seen); end
        checks++; if (bus.lo_data_out !== 32'd42 || bus.hi_data_out !== 32'd0) begin
            errors++; $display("FAIL flush_retain: got lo=%h hi=%h exp 2a/0", bus.lo_data_out, bus.hi_data_out); end
        bus.start = 1'b1; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL flush_start: got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        bus.en = 1'b0; bus.start = 1'b1;
        tick();
        bus.en = 1'b1; bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL en_low_start: got %b exp 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat; int busy_seen;
        bus.data_a_in = 32'd10; bus.data_b_in = 32'd10; bus.op_div = 1'b0; bus.start = 1'b1;
        tick();
        bus.data_a_in = 32'd3; bus.data_b_in = 32'd0; bus.op_div = 1'b1;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            bus.start = (lat < 4);
            tick(); lat++;
        end
        bus.start = 1'b0;
        checks++; if (lat != LAT || bus.lo_data_out !== 32'd100 || bus.div_zero_err !== 1'b0) begin
            errors++; $display("FAIL start_ignored: got lo=%0d dz=%b lat=%0d exp 100/0/%0d", bus.lo_data_out, bus.div_zero_err, lat, LAT); end
        tick();
        busy_seen = 0;
        repeat (3) begin
            if (bus.busy === 1'b1 || bus.done === 1'b1) busy_seen++;
            tick();
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL no_queue: got %0d exp 0", busy_seen); end
    endtask

    task automatic test_en_stall();
        int lat;
        bus.data_a_in = 32'd12; bus.data_b_in = 32'd12; bus.op_div = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        repeat (5) begin tick(); lat++; end
        bus.en = 1'b0;
        repeat (5) begin tick(); lat++; end
        bus.en = 1'b1;
        while (bus.done !== 1'b1 && lat < 100) begin tick(); lat++; end
        checks++; if (lat != LAT + 5 || bus.lo_data_out !== 32'd144) begin
            errors++; $display("FAIL en_stall: got lat=%0d lo=%0d exp %0d/144", lat, bus.lo_data_out, LAT + 5); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1; bus.start = 1'b0; bus.op_div = 1'b0; bus.op_signed = 1'b0;
        bus.flush = 1'b0; bus.data_a_in = '0; bus.data_b_in = '0;
        test_reset();
        test_mult();
        test_div();
        test_signed();
        test_random();
        test_flush();
        test_back_to_back();
        test_en_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
